// File: rtl/pt_cfg_pkg.sv
// Shared geometry, loader state encoding and flat-bus addressing for the
// product-term fuse loader.
package pt_cfg_pkg;

    localparam int unsigned PT_WIDTH  = 96;
    localparam int unsigned NUM_PT    = 5;
    localparam int unsigned FLB_BITS  = 16;
    localparam int unsigned UIM_BITS  = 40;
    localparam int unsigned BUS_WIDTH = PT_WIDTH * NUM_PT;
    localparam int unsigned BIT_CNT_W = $clog2(PT_WIDTH);
    localparam int unsigned ROW_CNT_W = $clog2(NUM_PT);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCommit,
        StErase
    } loader_state_e;

    function automatic int unsigned row_offset(input logic [ROW_CNT_W-1:0] row);
        return 32'(row) * PT_WIDTH;
    endfunction

endpackage

// File: rtl/fuse_shift_row.sv
// One-row shift register: parallel load of the old row, serial in at the MSB,
// displaced bit out of the LSB, with a bit counter flagging the final shift.
module fuse_shift_row
    import pt_cfg_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [PT_WIDTH-1:0] load_data,
    input  logic                shift_en,
    input  logic                sin,
    output logic                sout,
    output logic [PT_WIDTH-1:0] data,
    output logic                last_bit
);

    logic [PT_WIDTH-1:0]  shreg_q;
    logic [BIT_CNT_W-1:0] bitcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q  <= '1;
            bitcnt_q <= '0;
        end else if (load) begin
            shreg_q  <= load_data;
            bitcnt_q <= '0;
        end else if (shift_en) begin
            // After PT_WIDTH shifts the first bit received sits at bit 0.
            shreg_q  <= {sin, shreg_q[PT_WIDTH-1:1]};
            bitcnt_q <= bitcnt_q + BIT_CNT_W'(1);
        end
    end

    assign sout     = shreg_q[0];
    assign data     = shreg_q;
    assign last_bit = shift_en && (bitcnt_q == BIT_CNT_W'(PT_WIDTH - 1));

endmodule

// File: rtl/pt_fuse_loader.sv
// Serial fuse writer/readback for one macrocell's product-term rows; rows reach
// the AND-array bus only on a whole-row commit.
module pt_fuse_loader
    import pt_cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 erase,
    input  logic                 sin_valid,
    input  logic                 sin_data,
    output logic                 sin_ready,
    output logic                 rb_data,
    output logic                 busy,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] ptbitmap_mux
);

    loader_state_e         state_q, state_d;
    logic [ROW_CNT_W-1:0]  row_q, row_d;
    logic [BUS_WIDTH-1:0]  bus_q;
    logic [PT_WIDTH-1:0]   shreg, row_data;
    logic                  shift_en, last_bit, sout, last_row;

    assign last_row = (row_q == ROW_CNT_W'(NUM_PT - 1));
    assign row_data = bus_q[row_offset(row_q) +: PT_WIDTH];
    assign shift_en = (state_q == StShift) && sin_valid;

    fuse_shift_row u_shift_row (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state_q == StLoad),
        .load_data (row_data),
        .shift_en  (shift_en),
        .sin       (sin_data),
        .sout      (sout),
        .data      (shreg),
        .last_bit  (last_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                if (erase) begin
                    state_d = StErase;
                    row_d   = '0;
                end else if (start) begin
                    state_d = StLoad;
                    row_d   = '0;
                end
            end
            StLoad:  state_d = StShift;
            StShift: if (last_bit) state_d = StCommit;
            StCommit, StErase: begin
                if (last_row) begin
                    state_d = StIdle;
                    row_d   = '0;
                end else begin
                    state_d = (state_q == StErase) ? StErase : StLoad;
                    row_d   = row_q + ROW_CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                row_d   = '0;
            end
        endcase
    end

    // The bus is the only copy of the fuse rows; it changes only in COMMIT/ERASE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q <= '1;
        end else if (state_q == StCommit) begin
            bus_q[row_offset(row_q) +: PT_WIDTH] <= shreg;
        end else if (state_q == StErase) begin
            bus_q[row_offset(row_q) +: PT_WIDTH] <= '1;
        end
    end

    always_comb begin
        sin_ready = (state_q == StShift);
        rb_data   = sin_ready & sout;
        busy      = (state_q != StIdle);
        done      = ((state_q == StCommit) || (state_q == StErase)) && last_row;
    end

    assign ptbitmap_mux = bus_q;

endmodule

// File: tb/tb_pt_fuse_loader.sv
// Randomized scoreboard bench for pt_fuse_loader: expected readback bits are
// queued per row from a row-array model and checked by an independent monitor.
module tb_pt_fuse_loader;
    import pt_cfg_pkg::*;

    localparam int W  = PT_WIDTH;
    localparam int NP = NUM_PT;
    localparam int BW = W * NP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          erase = 1'b0;
    logic          sin_valid = 1'b0;
    logic          sin_data = 1'b0;
    logic          sin_ready, rb_data, busy, done;
    logic [BW-1:0] ptbitmap_mux;

    int            vectors = 0;
    int            miscompares = 0;
    int            done_cnt = 0;
    bit            rb_q[$];
    logic [W-1:0]  model[NP];
    logic [W-1:0]  next_rows[NP];

    always #5 clk = ~clk;

    pt_fuse_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .erase        (erase),
        .sin_valid    (sin_valid),
        .sin_data     (sin_data),
        .sin_ready    (sin_ready),
        .rb_data      (rb_data),
        .busy         (busy),
        .done         (done),
        .ptbitmap_mux (ptbitmap_mux)
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_bus();
        logic [BW-1:0] b;
        for (int r = 0; r < NP; r++) b[r*W +: W] = model[r];
        return b;
    endfunction

    // Monitor: every accepted bit must displace the next expected old fuse bit.
    always @(negedge clk) begin : monitor
        bit e;
        if (rst_n) begin
            if (done) done_cnt++;
            if (sin_valid && sin_ready) begin
                if (rb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rb_unexpected: transfer with rb_data=%0b, expected none", rb_data);
                end else begin
                    e = rb_q.pop_front();
                    check("rb_data", BW'(rb_data), BW'(e));
                end
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (!sin_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!sin_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: sin_ready=0 after 20 cycles, expected 1");
        end
    endtask

    task automatic send_bit(input bit b, input int gap);
        sin_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        sin_valid = 1'b1;
        sin_data  = b;
        wait_ready();
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
    endtask

    task automatic rand_rows();
        for (int r = 0; r < NP; r++) next_rows[r] = {$urandom(), $urandom(), $urandom()};
    endtask

    // Caller is #1 after a posedge with the loader idle.
    task automatic run_pass(input int gap_max, input bit glitch, input int abort_row,
                            input int abort_bits);
        int d0 = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("ready_in_load", BW'(sin_ready), BW'(0));
        check("busy_in_load", BW'(busy), BW'(1));
        @(negedge clk);
        check("start_to_ready", BW'(sin_ready), BW'(1));
        @(posedge clk);
        #1;
        for (int r = 0; r < NP; r++) begin
            wait_ready();
            check($sformatf("bus_row%0d_start", r), ptbitmap_mux, model_bus());
            @(posedge clk);
            #1;
            for (int b = 0; b < W; b++) rb_q.push_back(model[r][b]);
            if (glitch && r == 1) begin
                start = 1'b1;
                erase = 1'b1;
            end
            if (glitch && r == 3) begin
                start = 1'b0;
                erase = 1'b0;
            end
            for (int b = 0; b < W; b++) begin
                if (r == abort_row && b == abort_bits) begin
                    check("bus_mid_row", ptbitmap_mux, model_bus());
                    return;
                end
                send_bit(next_rows[r][b], gap_max == 0 ? 0 : int'($urandom_range(gap_max, 0)));
            end
            model[r] = next_rows[r];
        end
        @(negedge clk);
        check("done_after_last_bit", BW'(done), BW'(1));
        @(negedge clk);
        check("done_one_cycle", BW'(done), BW'(0));
        check("idle_after_pass", BW'(busy), BW'(0));
        check("bus_after_pass", ptbitmap_mux, model_bus());
        check("done_count_pass", BW'(done_cnt - d0), BW'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic run_erase();
        int d0 = done_cnt;
        erase = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        erase = 1'b0;
        start = 1'b0;
        for (int i = 1; i <= NP; i++) begin
            @(negedge clk);
            check($sformatf("erase_busy_%0d", i), BW'(busy), BW'(1));
            check($sformatf("erase_no_ready_%0d", i), BW'(sin_ready), BW'(0));
            check($sformatf("erase_done_%0d", i), BW'(done), BW'(i == NP));
        end
        for (int r = 0; r < NP; r++) model[r] = '1;
        @(negedge clk);
        check("bus_after_erase", ptbitmap_mux, model_bus());
        check("idle_after_erase", BW'(busy), BW'(0));
        check("done_count_erase", BW'(done_cnt - d0), BW'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < NP; r++) model[r] = '1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("reset_bus", ptbitmap_mux, {BW{1'b1}});
        check("reset_busy", BW'(busy), BW'(0));
        check("reset_done", BW'(done), BW'(0));
        check("reset_ready", BW'(sin_ready), BW'(0));
        check("reset_rb", BW'(rb_data), BW'(0));

        next_rows[0] = '0;
        for (int r = 1; r < NP; r++) next_rows[r] = 96'hFFFF_0000_FFFF_0000_FFFF_0000;
        run_pass(0, 1'b0, -1, 0);
        check("row0_zero", BW'(ptbitmap_mux[W-1:0]), '0);

        for (int r = 0; r < NP; r++) next_rows[r] = {48{2'b01}};
        run_pass(0, 1'b0, -1, 0);

        rand_rows();
        run_pass(5, 1'b1, -1, 0);

        // Abort part-way through row 2, then reset asynchronously.
        rand_rows();
        run_pass(0, 1'b0, 2, 50);
        rb_q.delete();
        #2 rst_n = 1'b0;
        #1;
        for (int r = 0; r < NP; r++) model[r] = '1;
        check("async_reset_bus", ptbitmap_mux, model_bus());
        check("async_reset_busy", BW'(busy), BW'(0));
        check("async_reset_ready", BW'(sin_ready), BW'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        rand_rows();
        run_pass(2, 1'b0, -1, 0);
        run_erase();

        rand_rows();
        run_pass(1, 1'b0, -1, 0);
        check("rb_queue_drained", BW'(rb_q.size()), BW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
